poly_stereo_mixer: RTL and testbench



---
 rtl/poly_stereo_mixer_pkg.sv | 21 ++
 rtl/poly_stereo_mixer_sat_shift.sv | 40 ++++
 rtl/poly_stereo_mixer.sv | 134 +++++++++++++
 tb/tb_poly_stereo_mixer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/poly_stereo_mixer_pkg.sv
// Shared constants for the stereo mixer: pan codes, FSM state encoding and
// the accumulator sizing rule.
package poly_stereo_mixer_pkg;

  localparam logic [1:0] PAN_CENTER = 2'd0;
  localparam logic [1:0] PAN_LEFT   = 2'd1;
  localparam logic [1:0] PAN_RIGHT  = 2'd2;
  localparam logic [1:0] PAN_MUTE   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_SCALE = 2'd2
  } state_t;

  // Wide enough that summing every voice at full scale cannot wrap.
  function automatic int acc_width(input int in_w, input int num_voices);
    return in_w + $clog2(num_voices) + 1;
  endfunction

endpackage

// File: rtl/poly_stereo_mixer_sat_shift.sv
// Combinational arithmetic right shift followed by saturation from the
// accumulator width down to the output width, flagging any clamp.
module sat_shift #(
  parameter int ACC_W = 19,
  parameter int OUT_W = 16
) (
  input  logic signed [ACC_W-1:0] i_acc,
  input  logic        [1:0]       i_shift,
  output logic signed [OUT_W-1:0] o_sample,
  output logic                    o_clipped
);

  // OUT_W may exceed ACC_W for a single voice, so compare in a width that
  // holds both ranges plus a sign bit.
  localparam int EXT_W = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;

  localparam logic signed [EXT_W-1:0] SAT_MAX =
    {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] SAT_MIN =
    {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [EXT_W-1:0] w_ext;
  logic signed [EXT_W-1:0] w_shifted;

  assign w_ext     = {{(EXT_W-ACC_W){i_acc[ACC_W-1]}}, i_acc};
  assign w_shifted = w_ext >>> i_shift;

  always_comb begin
    o_sample  = w_shifted[OUT_W-1:0];
    o_clipped = 1'b0;
    if (w_shifted > SAT_MAX) begin
      o_sample  = SAT_MAX[OUT_W-1:0];
      o_clipped = 1'b1;
    end else if (w_shifted < SAT_MIN) begin
      o_sample  = SAT_MIN[OUT_W-1:0];
      o_clipped = 1'b1;
    end
  end

endmodule

// File: rtl/poly_stereo_mixer.sv
// Time-multiplexed stereo mixer: snapshots all voices on start, accumulates
// one voice per cycle under pan control, then shifts, saturates and strobes done.
module poly_stereo_mixer
  import poly_stereo_mixer_pkg::*;
#(
  parameter int NUM_VOICES = 3,
  parameter int IN_W       = 16,
  parameter int OUT_W      = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [NUM_VOICES*IN_W-1:0]   voice_samples,
  input  logic [2*NUM_VOICES-1:0]      voice_pan,
  input  logic [1:0]                   master_shift,
  input  logic                         clip_clear,
  output logic                         busy,
  output logic                         done,
  output logic signed [OUT_W-1:0]      sample_left,
  output logic signed [OUT_W-1:0]      sample_right,
  output logic                         clip,
  output logic                         overrun
);

  localparam int ACC_W = acc_width(IN_W, NUM_VOICES);
  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  state_t                      r_state;
  logic [IDX_W-1:0]            r_idx;
  logic [NUM_VOICES*IN_W-1:0]  r_samples;
  logic [2*NUM_VOICES-1:0]     r_pans;
  logic signed [ACC_W-1:0]     r_acc_l;
  logic signed [ACC_W-1:0]     r_acc_r;
  logic signed [OUT_W-1:0]     r_left;
  logic signed [OUT_W-1:0]     r_right;
  logic                        r_done;
  logic                        r_clip;
  logic                        r_overrun;

  logic signed [IN_W-1:0]      w_voice;
  logic signed [ACC_W-1:0]     w_voice_ext;
  logic [1:0]                  w_pan;
  logic                        w_add_l;
  logic                        w_add_r;
  logic                        w_busy;
  logic signed [OUT_W-1:0]     w_sat_l;
  logic signed [OUT_W-1:0]     w_sat_r;
  logic                        w_clip_l;
  logic                        w_clip_r;

  assign w_voice     = r_samples[r_idx*IN_W +: IN_W];
  assign w_pan       = r_pans[r_idx*2 +: 2];
  assign w_voice_ext = {{(ACC_W-IN_W){w_voice[IN_W-1]}}, w_voice};
  assign w_add_l     = (w_pan == PAN_CENTER) || (w_pan == PAN_LEFT);
  assign w_add_r     = (w_pan == PAN_CENTER) || (w_pan == PAN_RIGHT);
  assign w_busy      = (r_state != ST_IDLE);

  sat_shift #(.ACC_W(ACC_W), .OUT_W(OUT_W)) u_sat_l (
    .i_acc     (r_acc_l),
    .i_shift   (master_shift),
    .o_sample  (w_sat_l),
    .o_clipped (w_clip_l)
  );

  sat_shift #(.ACC_W(ACC_W), .OUT_W(OUT_W)) u_sat_r (
    .i_acc     (r_acc_r),
    .i_shift   (master_shift),
    .o_sample  (w_sat_r),
    .o_clipped (w_clip_r)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_samples <= '0;
      r_pans    <= '0;
      r_acc_l   <= '0;
      r_acc_r   <= '0;
      r_left    <= '0;
      r_right   <= '0;
      r_done    <= 1'b0;
      r_clip    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_samples <= voice_samples;
            r_pans    <= voice_pan;
            r_acc_l   <= '0;
            r_acc_r   <= '0;
            r_idx     <= '0;
            r_state   <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (w_add_l) r_acc_l <= r_acc_l + w_voice_ext;
          if (w_add_r) r_acc_r <= r_acc_r + w_voice_ext;
          if (r_idx == LAST_IDX) r_state <= ST_SCALE;
          else                   r_idx   <= r_idx + 1'b1;
        end
        ST_SCALE: begin
          r_left  <= w_sat_l;
          r_right <= w_sat_r;
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase

      // Clear wins over a same-cycle set on both sticky flags.
      if (clip_clear)
        r_clip <= 1'b0;
      else if ((r_state == ST_SCALE) && (w_clip_l || w_clip_r))
        r_clip <= 1'b1;

      if (clip_clear)
        r_overrun <= 1'b0;
      else if (start && w_busy)
        r_overrun <= 1'b1;
    end
  end

  assign busy         = w_busy;
  assign done         = r_done;
  assign sample_left  = r_left;
  assign sample_right = r_right;
  assign clip         = r_clip;
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_poly_stereo_mixer.sv
// Self-checking bench for poly_stereo_mixer: directed scenarios plus randomized
// mixes compared against an arithmetic reference of the pan/shift/clamp rules.
module tb_poly_stereo_mixer;

  localparam int NV    = 3;
  localparam int IN_W  = 16;
  localparam int OUT_W = 16;
  localparam int MAXV  = (1 << (OUT_W-1)) - 1;
  localparam int MINV  = -(1 << (OUT_W-1));

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     start;
  logic [NV*IN_W-1:0]       voice_samples;
  logic [2*NV-1:0]          voice_pan;
  logic [1:0]               master_shift;
  logic                     clip_clear;
  logic                     busy;
  logic                     done;
  logic signed [OUT_W-1:0]  sample_left;
  logic signed [OUT_W-1:0]  sample_right;
  logic                     clip;
  logic                     overrun;

  int checks = 0;
  int errors = 0;
  int v_s[NV];
  int v_p[NV];
  int alt_s[NV];
  bit exp_clip = 1'b0;

  always #5 clk = ~clk;

  poly_stereo_mixer #(.NUM_VOICES(NV), .IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .voice_samples (voice_samples),
    .voice_pan     (voice_pan),
    .master_shift  (master_shift),
    .clip_clear    (clip_clear),
    .busy          (busy),
    .done          (done),
    .sample_left   (sample_left),
    .sample_right  (sample_right),
    .clip          (clip),
    .overrun       (overrun)
  );

  // Reference: pan 0 feeds both sides, 1 left only, 2 right only, 3 neither.
  function automatic int mix_exp(input bit left, input int shift, output bit clipped);
    int sum = 0;
    for (int v = 0; v < NV; v++)
      if (v_p[v] == 0 || (left && v_p[v] == 1) || (!left && v_p[v] == 2))
        sum += v_s[v];
    sum = sum >>> shift;
    clipped = 1'b0;
    if (sum > MAXV) begin sum = MAXV; clipped = 1'b1; end
    if (sum < MINV) begin sum = MINV; clipped = 1'b1; end
    return sum;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_voices(input bit use_alt);
    for (int v = 0; v < NV; v++) begin
      voice_samples[v*IN_W +: IN_W] = IN_W'(use_alt ? alt_s[v] : v_s[v]);
      voice_pan[v*2 +: 2]           = 2'(v_p[v]);
    end
  endtask

  // Starts a mix from v_s/v_p, scrambles the inputs afterwards, optionally
  // fires a second start at cycle inj_cyc, and collects done timing/outputs.
  task automatic run_mix(input int shift, input int inj_cyc, input int tail,
                         output int done_cyc, output int n_done, output int seq_err,
                         output int l, output int r);
    int cyc;
    drive_voices(1'b0);
    master_shift = 2'(shift);
    start = 1'b1;
    done_cyc = -1; n_done = 0; seq_err = 0; l = 0; r = 0;
    tick;
    cyc = 1;
    while (done_cyc < 0 && cyc <= NV + 6) begin
      if (busy !== (cyc <= NV + 1)) seq_err++;
      if (done === 1'b1) begin
        done_cyc = cyc; n_done++;
        l = int'(sample_left); r = int'(sample_right);
      end else begin
        if (cyc == inj_cyc) begin
          drive_voices(1'b1);
          start = 1'b1;
        end else begin
          start = 1'b0;
          voice_samples = {$urandom, $urandom};
          voice_pan = 6'($urandom);
        end
        tick;
        cyc++;
      end
    end
    start = 1'b0;
    for (int t = 0; t < tail; t++) begin
      tick;
      if (done === 1'b1) n_done++;
      if (int'(sample_left) != l || int'(sample_right) != r || busy !== 1'b0) seq_err++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b1; clip_clear = 1'b0; master_shift = 2'd0;
    v_s = '{100, 200, 300}; v_p = '{0, 0, 0};
    drive_voices(1'b0);
    tick; tick;
    checks++; if (sample_left !== 16'sd0 || sample_right !== 16'sd0) begin errors++;
      $display("FAIL reset_outputs: got L=%0d R=%0d expected 0/0", sample_left, sample_right); end
    checks++; if ({busy, done, clip, overrun} !== 4'b0000) begin errors++;
      $display("FAIL reset_flags: got busy/done/clip/overrun=%b expected 0000", {busy, done, clip, overrun}); end
    reset = 1'b0; start = 1'b0;
    tick;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++;
      $display("FAIL reset_start_ignored: got busy=%b done=%b expected 0/0", busy, done); end
  endtask

  task automatic test_center;
    int dc, nd, se, l, r;
    v_s = '{1000, 2000, -500}; v_p = '{0, 0, 0};
    run_mix(0, -1, 3, dc, nd, se, l, r);
    checks++; if (dc != NV + 2) begin errors++;
      $display("FAIL center_latency: got done cycle %0d expected %0d", dc, NV + 2); end
    checks++; if (se != 0 || nd != 1) begin errors++;
      $display("FAIL center_sequence: got busy/hold errors %0d, dones %0d expected 0, 1", se, nd); end
    checks++; if (l != 2500 || r != 2500) begin errors++;
      $display("FAIL center_value: got L=%0d R=%0d expected 2500/2500", l, r); end
    checks++; if (clip !== 1'b0) begin errors++;
      $display("FAIL center_clip: got %b expected 0", clip); end
  endtask

  task automatic test_panning;
    int dc, nd, se, l, r;
    v_s = '{1000, 2000, 3000}; v_p = '{1, 2, 3};
    run_mix(0, -1, 1, dc, nd, se, l, r);
    checks++; if (l != 1000 || r != 2000) begin errors++;
      $display("FAIL panning_value: got L=%0d R=%0d expected 1000/2000", l, r); end
    checks++; if (clip !== 1'b0 || se != 0) begin errors++;
      $display("FAIL panning_flags: got clip=%b seq errors %0d expected 0, 0", clip, se); end
  endtask

  task automatic test_saturation;
    int dc, nd, se, l, r;
    v_s = '{30000, 30000, 30000}; v_p = '{0, 0, 0};
    run_mix(0, -1, 1, dc, nd, se, l, r);
    checks++; if (l != 32767 || r != 32767 || clip !== 1'b1) begin errors++;
      $display("FAIL sat_pos: got L=%0d R=%0d clip=%b expected 32767/32767/1", l, r, clip); end
    run_mix(2, -1, 1, dc, nd, se, l, r);
    checks++; if (l != 22500 || r != 22500 || clip !== 1'b1) begin errors++;
      $display("FAIL sat_shift2: got L=%0d R=%0d clip=%b expected 22500/22500/1", l, r, clip); end
    v_s = '{-30000, -30000, -30000};
    run_mix(0, -1, 1, dc, nd, se, l, r);
    checks++; if (l != -32768 || r != -32768) begin errors++;
      $display("FAIL sat_neg: got L=%0d R=%0d expected -32768/-32768", l, r); end
    clip_clear = 1'b1; tick; clip_clear = 1'b0; tick;
    exp_clip = 1'b0;
    checks++; if (clip !== 1'b0) begin errors++;
      $display("FAIL clip_clear: got clip=%b expected 0", clip); end
  endtask

  task automatic test_overrun;
    int dc, nd, se, l, r;
    v_s = '{1234, -321, 777}; v_p = '{0, 1, 2};
    alt_s = '{-9000, 9000, 5555};
    run_mix(0, 2, 4, dc, nd, se, l, r);
    checks++; if (l != 1234 - 321 || r != 1234 + 777) begin errors++;
      $display("FAIL overrun_snapshot: got L=%0d R=%0d expected %0d/%0d", l, r, 1234 - 321, 1234 + 777); end
    checks++; if (nd != 1 || dc != NV + 2 || se != 0) begin errors++;
      $display("FAIL overrun_single_done: got dones %0d cycle %0d seq errors %0d expected 1, %0d, 0", nd, dc, se, NV + 2); end
    checks++; if (overrun !== 1'b1) begin errors++;
      $display("FAIL overrun_flag: got %b expected 1", overrun); end
    clip_clear = 1'b1; tick; clip_clear = 1'b0;
    checks++; if (overrun !== 1'b0) begin errors++;
      $display("FAIL overrun_clear: got %b expected 0", overrun); end
  endtask

  task automatic test_reset_mid;
    int dc, nd, se, l, r, n_done;
    v_s = '{4000, 4000, 4000}; v_p = '{0, 0, 0};
    drive_voices(1'b0);
    master_shift = 2'd0;
    start = 1'b1; tick;
    start = 1'b0; tick;
    reset = 1'b1; tick;
    reset = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || sample_left !== 16'sd0 || sample_right !== 16'sd0) begin errors++;
      $display("FAIL reset_mid_state: got busy=%b done=%b L=%0d R=%0d expected 0/0/0/0", busy, done, sample_left, sample_right); end
    n_done = 0;
    for (int i = 0; i < NV + 4; i++) begin tick; if (done === 1'b1) n_done++; end
    checks++; if (n_done != 0) begin errors++;
      $display("FAIL reset_mid_no_done: got %0d dones expected 0", n_done); end
    v_s = '{-100, 50, 25}; v_p = '{0, 0, 3};
    run_mix(1, -1, 1, dc, nd, se, l, r);
    checks++; if (l != -25 || r != -25 || dc != NV + 2) begin errors++;
      $display("FAIL reset_mid_fresh: got L=%0d R=%0d cycle %0d expected -25/-25/%0d", l, r, dc, NV + 2); end
  endtask

  task automatic test_back_to_back;
    int dc, nd, se, l, r;
    v_s = '{111, 222, 333}; v_p = '{0, 0, 0};
    run_mix(0, -1, 0, dc, nd, se, l, r);
    v_s = '{-5000, 6000, 7000}; v_p = '{2, 1, 0};
    run_mix(0, -1, 1, dc, nd, se, l, r);
    checks++; if (dc != NV + 2 || l != 13000 || r != 2000) begin errors++;
      $display("FAIL back_to_back: got cycle %0d L=%0d R=%0d expected %0d/13000/2000", dc, l, r, NV + 2); end
    checks++; if (overrun !== 1'b0) begin errors++;
      $display("FAIL back_to_back_overrun: got %b expected 0", overrun); end
  endtask

  task automatic test_random;
    int dc, nd, se, l, r, sh, el, er;
    bit cl, cr;
    for (int it = 0; it < 40; it++) begin
      for (int v = 0; v < NV; v++) begin
        v_s[v] = int'($urandom_range(65535)) - 32768;
        v_p[v] = int'($urandom_range(3));
      end
      sh = int'($urandom_range(3));
      el = mix_exp(1'b1, sh, cl);
      er = mix_exp(1'b0, sh, cr);
      exp_clip = exp_clip | cl | cr;
      run_mix(sh, -1, int'($urandom_range(2)), dc, nd, se, l, r);
      checks++; if (l != el || r != er || dc != NV + 2 || se != 0) begin errors++;
        $display("FAIL random_mix[%0d]: got L=%0d R=%0d cycle %0d seq %0d expected %0d/%0d/%0d/0", it, l, r, dc, se, el, er, NV + 2); end
      checks++; if (clip !== exp_clip) begin errors++;
        $display("FAIL random_clip[%0d]: got %b expected %b", it, clip, exp_clip); end
    end
    checks++; if (overrun !== 1'b0) begin errors++;
      $display("FAIL random_overrun: got %b expected 0", overrun); end
  endtask

  initial begin
    test_reset;
    test_center;
    test_panning;
    test_saturation;
    test_overrun;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
